isa_io_master: RTL and testbench
================================

Name: isa_io_master

Overview:
- Host-side ISA I/O cycle generator: the initiator that drives SA/AEN/IOR/IOW/SD toward the I/O-port decoders on the bus (e.g. the 0x2B0–0x2B3 port block).
- Accepts one read or write request at a time from the local controller.
- Sequences address setup, strobe, IOCHRDY wait-stretch and hold phases, then returns read data or completion.

Parameters:
- SETUP_CYC, 2, clocks SA valid (AEN low) before strobe asserts; legal 1..15
- STROBE_CYC, 4, minimum clocks IOR/IOW held low; legal 1..15
- HOLD_CYC, 1, clocks SA/SD held after strobe release; legal 1..15
- RDY_TIMEOUT, 255, maximum extra strobe clocks waiting on IOCHRDY; legal 1..1023

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when req_valid&req_ready
- req_write  in  1  1=IOW cycle, 0=IOR cycle
- req_addr  in  10  I/O port address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-clock completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid (held until next rsp)
- rsp_timeout  out  1  qualifies rsp_valid: IOCHRDY timeout occurred
- SA  out  10  bus address
- SD_out  out  8  bus write data
- SD_oe  out  1  1=drive SD (write cycles only)
- SD_in  in  8  bus data sampled on reads
- IOR  out  1  active-low I/O read strobe
- IOW  out  1  active-low I/O write strobe
- AEN  out  1  address enable, high=DMA/no I/O decode, low during master cycle
- IOCHRDY  in  1  target ready, low stretches strobe; synchronised internally (2 flops)

Behaviour:
- Reset values:
  - IOR=1, IOW=1, AEN=1, SD_oe=0, SA=0, SD_out=0.
  - req_ready=0 during reset, 1 one clock after rst_n deasserts.
  - rsp_valid=0, rsp_rdata=0, rsp_timeout=0.
- FSM states: IDLE, SETUP, STROBE, WAITRDY, HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On accept: latch addr/wdata/write, SA<=req_addr, AEN<=0, SD_oe<=req_write, SD_out<=req_wdata.
  - Load counter with SETUP_CYC and go to SETUP.
- SETUP:
  - Count down.
  - At terminal count, assert IOR (read) or IOW (write) low, load STROBE_CYC, go to STROBE.
- STROBE:
  - Count down.
  - At terminal count: if synced IOCHRDY=1, go to HOLD. Otherwise go to WAITRDY with timeout counter=0.
- WAITRDY:
  - Strobe stays low.
  - Exit to HOLD on the first clock synced IOCHRDY=1.
  - If the counter reaches RDY_TIMEOUT, set timeout flag and go to HOLD.
- Strobe release clock (entry to HOLD):
  - On a read, SD_in is captured into rsp_rdata on the same edge that releases IOR. Timeout reads capture SD_in as-is.
  - IOR/IOW return high.
  - SA, AEN=0 and SD_oe held for HOLD_CYC clocks.
- HOLD terminal: AEN<=1, SD_oe<=0, go to RESP. SA is held at its last value.
- RESP: rsp_valid=1 for exactly one clock, rsp_timeout=flag, then IDLE. req_ready returns the following clock.
- Latency, from accept edge to rsp_valid with no stretch: SETUP_CYC+STROBE_CYC+HOLD_CYC+1 clocks. Each WAITRDY clock adds 1.
- Invariants:
  - Back-to-back requests have at least 2 clocks with both strobes high.
  - IOR and IOW are never low simultaneously.
  - SD_oe=0 throughout read cycles.
- Request inputs are ignored while req_ready=0; there is no queueing.
- rst_n asserted mid-cycle: all outputs go to reset values immediately (asynchronously), and any in-flight response is discarded.
- Counters are 4-bit for the phase counters and 10-bit for the timeout counter. No wrap is permitted, since terminal counts are compared exactly.

Test Plan:
- Write 0x2B0 data 0x5A, defaults, IOCHRDY=1 -> AEN low 2 clk before IOW, IOW low exactly 4 clk, SD_oe=1 with SD_out=0x5A throughout, rsp_valid 8 clk after accept, rsp_timeout=0.
- Read 0x2B1, SD_in=0xC3 driven during strobe -> IOR low 4 clk, IOW stays 1, SD_oe=0, rsp_rdata=0xC3.
- Read with IOCHRDY low for 6 clk after strobe terminal -> IOR low 4+6 clk (plus sync delay), rsp_timeout=0, latency extended accordingly.
- IOCHRDY stuck low, RDY_TIMEOUT=8 -> IOR released after 4+8 clk, rsp_valid with rsp_timeout=1, next request accepted normally.
- req_valid held high continuously, alternating write 0x2B2 / read 0x2B3 -> one transaction per response, at least 2 clk both strobes high between cycles, IOR/IOW never simultaneously low.
- rst_n pulsed low during STROBE -> IOR/IOW/AEN return to 1 and SD_oe to 0 without waiting for clk, no rsp_valid, req_ready=1 one clk after release.

Source files
------------

// File: rtl/isa_io_master.sv
// isa_io_master: host-side ISA I/O cycle generator.
// Runs one IOR/IOW cycle at a time: address setup with AEN low, a strobe phase
// that IOCHRDY may stretch (bounded by a timeout), an address/data hold phase,
// then a one-clock completion pulse carrying read data and the timeout flag.
module isa_io_master #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RDY_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    // request side
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    // response side
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    // ISA bus
    output logic [9:0] SA,
    output logic [7:0] SD_out,
    output logic       SD_oe,
    input  logic [7:0] SD_in,
    output logic       IOR,
    output logic       IOW,
    output logic       AEN,
    input  logic       IOCHRDY
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWaitRdy,
        StHold,
        StResp
    } state_e;

    localparam logic [3:0] SetupCnt   = 4'(SETUP_CYC);
    localparam logic [3:0] StrobeCnt  = 4'(STROBE_CYC);
    localparam logic [3:0] HoldCnt    = 4'(HOLD_CYC);
    localparam logic [9:0] TimeoutCnt = 10'(RDY_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;        // phase counter, terminal count is 1
    logic [9:0] tcnt_q, tcnt_d;      // clocks spent in the IOCHRDY wait
    logic [9:0] tcnt_inc;
    logic       to_q, to_d;          // IOCHRDY timeout seen this cycle
    logic       write_q, write_d;
    logic       ready_q, ready_d;
    logic [9:0] sa_q, sa_d;
    logic       aen_q, aen_d;
    logic       ior_q, ior_d;
    logic       iow_q, iow_d;
    logic       sd_oe_q, sd_oe_d;
    logic [7:0] sd_out_q, sd_out_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rdy_meta_q, rdy_sync_q;
    logic       release_strobe;

    // Bring the asynchronous IOCHRDY into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
        end else begin
            rdy_meta_q <= IOCHRDY;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    // FSM state, counters and registered bus/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            tcnt_q   <= 10'd0;
            to_q     <= 1'b0;
            write_q  <= 1'b0;
            ready_q  <= 1'b0;
            sa_q     <= 10'd0;
            aen_q    <= 1'b1;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            sd_oe_q  <= 1'b0;
            sd_out_q <= 8'd0;
            rdata_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            to_q     <= to_d;
            write_q  <= write_d;
            ready_q  <= ready_d;
            sa_q     <= sa_d;
            aen_q    <= aen_d;
            ior_q    <= ior_d;
            iow_q    <= iow_d;
            sd_oe_q  <= sd_oe_d;
            sd_out_q <= sd_out_d;
            rdata_q  <= rdata_d;
        end
    end

    assign tcnt_inc = tcnt_q + 10'd1;

    // Next-state logic: sequence setup, strobe, ready-wait and hold phases.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tcnt_d         = tcnt_q;
        to_d           = to_q;
        write_d        = write_q;
        sa_d           = sa_q;
        aen_d          = aen_q;
        ior_d          = ior_q;
        iow_d          = iow_q;
        sd_oe_d        = sd_oe_q;
        sd_out_d       = sd_out_q;
        rdata_d        = rdata_q;
        release_strobe = 1'b0;

        unique case (state_q)
            StIdle: begin
                // ready_q is only ever set while idle, so it gates the accept.
                if (req_valid && ready_q) begin
                    write_d  = req_write;
                    sa_d     = req_addr;
                    aen_d    = 1'b0;
                    sd_oe_d  = req_write;
                    sd_out_d = req_wdata;
                    to_d     = 1'b0;
                    cnt_d    = SetupCnt;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 4'd1) begin
                    ior_d   = write_q;
                    iow_d   = !write_q;
                    cnt_d   = StrobeCnt;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == 4'd1) begin
                    if (rdy_sync_q) begin
                        release_strobe = 1'b1;
                    end else begin
                        tcnt_d  = 10'd0;
                        state_d = StWaitRdy;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWaitRdy: begin
                // A target that becomes ready on the last allowed clock wins.
                if (rdy_sync_q) begin
                    release_strobe = 1'b1;
                end else if (tcnt_inc == TimeoutCnt) begin
                    to_d           = 1'b1;
                    release_strobe = 1'b1;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            StHold: begin
                if (cnt_q == 4'd1) begin
                    aen_d   = 1'b1;
                    sd_oe_d = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobe release edge: reads capture SD_in here, timed out or not.
        if (release_strobe) begin
            ior_d   = 1'b1;
            iow_d   = 1'b1;
            if (!write_q) begin
                rdata_d = SD_in;
            end
            cnt_d   = HoldCnt;
            state_d = StHold;
        end

        ready_d = (state_d == StIdle);
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_timeout = rsp_valid & to_q;
    assign rsp_rdata   = rdata_q;
    assign SA          = sa_q;
    assign SD_out      = sd_out_q;
    assign SD_oe       = sd_oe_q;
    assign IOR         = ior_q;
    assign IOW         = iow_q;
    assign AEN         = aen_q;

    // Bus-level safety properties.
    a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n) (ior_q || iow_q));
    a_read_no_drive: assert property (@(posedge clk) disable iff (!rst_n) (sd_oe_q -> write_q));

endmodule

// File: tb/tb_isa_io_master.sv
// Bench for isa_io_master: random and directed I/O cycles checked against a
// timing model derived from phase lengths and the IOCHRDY low window.
module tb_isa_io_master;

    localparam int S  = 2;
    localparam int T  = 4;
    localparam int H  = 1;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [9:0] req_addr = 10'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic [9:0] SA;
    logic [7:0] SD_out;
    logic       SD_oe;
    logic [7:0] SD_in = 8'd0;
    logic       IOR;
    logic       IOW;
    logic       AEN;
    logic       IOCHRDY = 1'b1;

    always #5 clk = ~clk;

    isa_io_master #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H),
        .RDY_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .SA         (SA),
        .SD_out     (SD_out),
        .SD_oe      (SD_oe),
        .SD_in      (SD_in),
        .IOR        (IOR),
        .IOW        (IOW),
        .AEN        (AEN),
        .IOCHRDY    (IOCHRDY)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;          // index of the most recent rising edge
    int         low_from = 1;     // IOCHRDY is low at edges low_from..low_until
    int         low_until = 0;
    logic [7:0] sd_rd = 8'd0;     // data the target returns during the strobe
    logic [7:0] last_rdata = 8'd0;
    int         hi_run = 0;       // consecutive samples with both strobes high
    bit         have_prev = 1'b0;
    bit         rsp_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Target model: IOCHRDY follows the planned low window; SD_in carries the
    // read data only while IOR is low so a mistimed capture is visible.
    always @(negedge clk) begin
        #1;
        IOCHRDY = !((cyc + 1 >= low_from) && (cyc + 1 <= low_until));
        SD_in   = (IOR == 1'b0) ? sd_rd : ~sd_rd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic upd_run();
        if (IOR && IOW) hi_run++;
        else hi_run = 0;
    endtask

    // Extra strobe clocks for an IOCHRDY low window of e edges after accept.
    // The synchroniser means the strobe terminal edge sees the line as it was
    // two edges earlier.
    function automatic int exp_wait(input int e);
        int j0;
        j0 = e - (S + T - 2) + 1;
        if (j0 <= 0) return 0;
        if (j0 <= TO) return j0;
        return TO;
    endfunction

    task automatic run_txn(input bit wr, input logic [9:0] addr, input logic [7:0] data,
                           input int e, input bit cont);
        int   a, w, lat, n;
        bit   to, seen_strobe, got_rsp;
        int   ior_n, iow_n, both_n, aen_n, aen_pre, sa_bad, oe_bad, do_bad;
        logic [7:0] exp_rd;
        ior_n = 0; iow_n = 0; both_n = 0; aen_n = 0; aen_pre = 0;
        sa_bad = 0; oe_bad = 0; do_bad = 0; lat = 0;
        seen_strobe = 1'b0; got_rsp = 1'b0;

        @(negedge clk);
        if (rsp_prev) begin
            check("rsp_pulse_width", rsp_valid, 0);
            rsp_prev = 1'b0;
        end
        n = 0;
        upd_run();
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
            upd_run();
        end
        if (!req_ready) begin
            check("ready_wait", req_ready, 1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        a         = cyc + 1;
        low_from  = a + 1;
        low_until = a + e;
        sd_rd     = data;
        w         = exp_wait(e);
        to        = (e - (S + T - 2) + 1) > TO;

        n = 0;
        while (!got_rsp && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) check("ready_drop", req_ready, 0);
            req_valid = cont;
            req_addr  = 10'($urandom);
            req_wdata = 8'($urandom);
            req_write = 1'($urandom);
            if ((!IOR || !IOW) && !seen_strobe) begin
                seen_strobe = 1'b1;
                if (have_prev) check("strobe_gap", hi_run >= 2, 1);
                have_prev = 1'b1;
            end
            upd_run();
            if (!IOR) ior_n++;
            if (!IOW) iow_n++;
            if (!IOR && !IOW) both_n++;
            if (!AEN) begin
                aen_n++;
                if (!seen_strobe) aen_pre++;
                if (SA != addr) sa_bad++;
                if (SD_oe != wr) oe_bad++;
                if (SD_oe && SD_out != data) do_bad++;
            end else if (SD_oe) begin
                oe_bad++;
            end
            if (rsp_valid) begin
                got_rsp = 1'b1;
                lat     = cyc + 1 - a;
            end
        end
        check("rsp_seen", got_rsp, 1);
        if (!got_rsp) return;
        check("latency", lat, S + T + H + 1 + w);
        check("strobe_len", wr ? iow_n : ior_n, T + w);
        check("other_strobe", wr ? ior_n : iow_n, 0);
        check("dual_strobe", both_n, 0);
        check("aen_len", aen_n, S + T + w + H);
        check("aen_setup", aen_pre, S);
        check("sa_hold", sa_bad, 0);
        check("sd_oe", oe_bad, 0);
        check("sd_out", do_bad, 0);
        check("rsp_timeout", rsp_timeout, to);
        exp_rd = wr ? last_rdata : data;
        check("rsp_rdata", rsp_rdata, exp_rd);
        last_rdata = exp_rd;
        rsp_prev   = 1'b1;
    endtask

    task automatic reset_midcycle();
        int n, rsp_n;
        rsp_n = 0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'h2B1;
        sd_rd     = 8'h77;
        low_from  = cyc + 2;
        low_until = 0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (IOR && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_strobe_seen", IOR, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_bus", {IOR, IOW, AEN, SD_oe}, 4'b1110);
        check("rst_async_ready", req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_n++;
        end
        rst_n = 1'b1;
        check("rst_release_ready", req_ready, 0);
        @(negedge clk);
        check("rst_ready_back", req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) rsp_n++;
            @(negedge clk);
        end
        check("rst_no_rsp", rsp_n, 0);
        check("rst_rdata", rsp_rdata, 0);
        last_rdata = 8'd0;
        have_prev  = 1'b0;
        rsp_prev   = 1'b0;
        hi_run     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timed out");
    end

    initial begin
        bit         wr;
        int         e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {IOR, IOW, AEN, SD_oe, req_ready, rsp_valid, rsp_timeout},
              7'b1110000);
        check("reset_sa", SA, 0);
        check("reset_sd_out", SD_out, 0);
        check("reset_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        check("ready_in_release", req_ready, 0);
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Directed cycles: plain write/read, stretches, timeout boundaries.
        run_txn(1'b1, 10'h2B0, 8'h5A, 0, 1'b0);
        run_txn(1'b0, 10'h2B1, 8'hC3, 0, 1'b0);
        run_txn(1'b0, 10'h2B1, 8'h3C, 9, 1'b0);
        run_txn(1'b0, 10'h2B1, 8'h96, 11, 1'b0);
        run_txn(1'b0, 10'h2B1, 8'h69, 12, 1'b0);
        run_txn(1'b0, 10'h2B1, 8'hE1, 1000, 1'b0);
        run_txn(1'b1, 10'h2B0, 8'hA5, 0, 1'b0);

        // req_valid held high, alternating write 0x2B2 / read 0x2B3.
        for (int i = 0; i < 8; i++) begin
            wr = (i % 2) == 0;
            run_txn(wr, wr ? 10'h2B2 : 10'h2B3, 8'($urandom), $urandom_range(0, 15), 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            e = ($urandom_range(0, 5) == 0) ? 1000 : $urandom_range(0, 14);
            run_txn(1'($urandom), 10'($urandom), 8'($urandom), e, 1'($urandom));
        end

        req_valid = 1'b0;
        reset_midcycle();
        run_txn(1'b0, 10'h2B3, 8'h4E, 0, 1'b0);
        @(negedge clk);
        check("final_pulse_width", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
